// File: rtl/mealy_stream_checker.sv
// Captures a serial doutx/douty stream after a start pulse and compares it
// sample-by-sample against expected constants, reporting error statistics.
module mealy_stream_checker #(
    parameter int                 SAMPLES = 11,
    parameter int                 LATENCY = 2,
    parameter logic [SAMPLES-1:0] EXP_X   = 11'b00111111010,
    parameter logic [SAMPLES-1:0] EXP_Y   = 11'b00000001010
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         doutx,
    input  logic                         douty,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [$clog2(SAMPLES+1)-1:0] err_count,
    output logic [$clog2(SAMPLES)-1:0]   first_err_idx,
    output logic [SAMPLES-1:0]           x_capture,
    output logic [SAMPLES-1:0]           y_capture
);

    localparam int CW = $clog2(SAMPLES + 1);
    localparam int IW = $clog2(SAMPLES);
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   k;
    logic [LW-1:0]   wcnt;
    logic [IW-1:0]   idx;
    logic            mism;

    // Sample k lands at bit SAMPLES-1-k, MSB-first like the expected vectors
    always_comb begin
        idx  = IW'(SAMPLES - 1) - k;
        mism = (doutx != EXP_X[idx]) || (douty != EXP_Y[idx]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
            x_capture     <= '0;
            y_capture     <= '0;
            k             <= '0;
            wcnt          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_err_idx <= '1;
                        x_capture     <= '0;
                        y_capture     <= '0;
                        k             <= '0;
                        wcnt          <= '0;
                        busy          <= 1'b1;
                        state         <= (LATENCY == 0) ? CAPTURE : WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (wcnt == LW'(LATENCY - 1)) begin
                        state <= CAPTURE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    x_capture[idx] <= doutx;
                    y_capture[idx] <= douty;
                    if (mism) begin
                        err_count <= err_count + CW'(1);
                        if (first_err_idx == '1) begin
                            first_err_idx <= k;
                        end
                    end
                    if (k == IW'(SAMPLES - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mism;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mealy_stream_checker.md
MEALY_STREAM_CHECKER -- requirements
Module: mealy_stream_checker

Interface
REQ-001 The block SHALL have the parameter SAMPLES, default 11, giving the number of output samples captured per run (minimum 2).
REQ-002 The block SHALL have the parameter LATENCY, default 2, giving the cycles between accepted start and the first sample (0 allowed).
REQ-003 The block SHALL have the parameter EXP_X, default 11'b00111111010, giving the expected doutx stream; the bit at position SAMPLES-1 is sample 0.
REQ-004 The block SHALL have the parameter EXP_Y, default 11'b00000001010, giving the expected douty stream in the same ordering as EXP_X.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-007 The block SHALL have the port start, input, 1 bit: one-cycle run request.
REQ-008 The block SHALL have the port doutx, input, 1 bit: serial x output of the model under test.
REQ-009 The block SHALL have the port douty, input, 1 bit: serial y output of the model under test.
REQ-010 The block SHALL have the port busy, output, 1 bit: high in the WAIT and CAPTURE states.
REQ-011 The block SHALL have the port done, output, 1 bit: one-cycle pulse when a run completes.
REQ-012 The block SHALL have the port pass, output, 1 bit: high when the last completed run had zero mismatches.
REQ-013 The block SHALL have the port err_count, output, $clog2(SAMPLES+1) bits: the number of mismatching samples.
REQ-014 The block SHALL have the port first_err_idx, output, $clog2(SAMPLES) bits: the index of the first mismatching sample, or all-ones if there is none.
REQ-015 The block SHALL have the port x_capture, output, SAMPLES bits: the captured doutx stream, with sample 0 at bit SAMPLES-1.
REQ-016 The block SHALL have the port y_capture, output, SAMPLES bits: the captured douty stream in the same ordering as x_capture.

Function
REQ-017 The block SHALL implement the FSM states IDLE, WAIT, CAPTURE and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL clear err_count, x_capture, y_capture and pass, set first_err_idx to all-ones, and move to WAIT (LATENCY>0) or to CAPTURE (LATENCY=0).
REQ-019 WAIT SHALL count LATENCY rising edges, with the start edge counted as edge 0, then move to CAPTURE; start is ignored in WAIT.
REQ-020 With start sampled at edge E, sample k SHALL be taken at edge E+LATENCY+1+k, for k = 0..SAMPLES-1.
REQ-021 Each CAPTURE edge SHALL write doutx/douty into x_capture/y_capture at bit SAMPLES-1-k.
REQ-022 A sample SHALL be a mismatch when doutx != EXP_X[SAMPLES-1-k] or douty != EXP_Y[SAMPLES-1-k]; a sample where both differ counts once.
REQ-023 On a mismatch, err_count SHALL increment by 1 (saturating is unnecessary: the maximum is SAMPLES), and first_err_idx SHALL load k if it is still all-ones.
REQ-024 After sample SAMPLES-1, the FSM SHALL enter DONE for exactly one cycle with done=1 and pass=(final err_count==0), then return to IDLE unless start=1.
REQ-025 The registered outputs pass, err_count, first_err_idx, x_capture and y_capture SHALL be valid from the done cycle and held until the next accepted start.
REQ-026 start asserted in WAIT or CAPTURE SHALL have no effect on state, counters or results.

Reset
REQ-027 reset=1 at a rising edge SHALL, in any state including mid-CAPTURE, force IDLE, busy=0, done=0, pass=0, err_count=0, first_err_idx=all-ones and x_capture=y_capture=0.
REQ-028 reset SHALL take priority over start in the same cycle.

Verification
REQ-029 Reset scenario: hold reset for 2 cycles -> busy=0, done=0, pass=0, err_count=0, first_err_idx=4'hF, x_capture=y_capture=0.
REQ-030 Match scenario (defaults): start at edge 0, drive EXP_X/EXP_Y sample k at edge 3+k -> done high in the cycle after edge 13, pass=1, err_count=0, x_capture=11'b00111111010.
REQ-031 Single-error scenario: as REQ-030 but doutx inverted at sample 4 -> pass=0, err_count=1, first_err_idx=4, x_capture=11'b00111011010.
REQ-032 Double-error scenario: douty inverted at samples 2 and 9, and doutx also inverted at sample 9 -> err_count=2, first_err_idx=2, pass=0.
REQ-033 Start-while-busy scenario: extra start pulses at edges 1 and 6 -> done occurs once after edge 13 and results are unchanged versus REQ-030.
REQ-034 Abort-and-back-to-back scenario: reset at sample 5 -> all outputs per REQ-027; then start in the done cycle of a completed run -> new run begins with busy=1 on the next cycle and results cleared.
